// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter (LSB first) fed from an internal
// circular write FIFO. Queued bytes are sent back-to-back with no idle gap
// between frames. tx_pin comes straight from a flop so the line never glitches.
module uart_tx_fifo #(
    parameter int BAUD_PRESCALER = 434,
    parameter int FIFO_AW        = 4
) (
    input  logic               i_clk,
    input  logic               _rst,
    input  logic [7:0]         data,
    input  logic               write,
    output logic               tx_pin,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count,
    output logic               busy,
    output logic               overflow
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CNT_W = $clog2(BAUD_PRESCALER);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_PRESCALER - 1);
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] rptr_q, rptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               ovf_q, ovf_d;
    logic [7:0]         mem_q [DEPTH];

    logic               push;
    logic               pop;
    logic               baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    // FIFO bookkeeping: a push is taken only when not full; pop comes from the FSM.
    always_comb begin
        push    = write && !full_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q | (write & full_q);
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);
    end

    // Frame sequencer: next state, pop decision and the next line level.
    // The line level is registered, so it trails the state by one cycle;
    // every segment is still exactly BAUD_PRESCALER cycles long.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_end) begin
                    if (!empty_q) begin
                        // Chain straight into the next frame: no idle gap.
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        bit_d   = '0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and status registers; reset forces the line high at once.
    always_ff @(posedge i_clk or negedge _rst) begin
        if (!_rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
        end
    end

    // Data storage: FIFO array and shift register hold no control state.
    always_ff @(posedge i_clk) begin
        shift_q <= shift_d;
        if (push) begin
            mem_q[wptr_q] <= data;
        end
    end

    assign tx_pin   = tx_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign busy     = (state_q != IDLE);
    assign overflow = ovf_q;

endmodule
